// File: rtl/dpram_clr_pkg.sv
// ============================================================================
// Package : dpram_clr_pkg
// Shared state encodings and byte-lane helpers for the clearable dual-port RAM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dpram_clr_pkg;

   // Width of one byte lane; data words are built from whole lanes
   localparam int BYTE_W = 8;

   // Sweep controller states: CLEAR fills the array, RUN is normal access
   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } sweep_state_e;

   // Number of byte lanes in a data word of width dw
   function automatic int lanes(input int dw);
      return dw / BYTE_W;
   endfunction

endpackage : dpram_clr_pkg

`default_nettype wire

// File: rtl/dpram_clr_ram_sweep.sv
// ============================================================================
// Module  : ram_sweep
// Post-reset clear sequencer. Walks an address counter over the whole array,
// strobing a write each cycle, then raises ready and stays in RUN until the
// next reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_sweep
   import dpram_clr_pkg::*;
#(
   parameter int AW    = 10,
   parameter bit CLREN = 1'b1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   output logic [AW-1:0] addr_o,
   output logic          we_o,
   output logic          ready_o
);

   // Last address of the array; the counter stops here instead of wrapping
   localparam logic [AW-1:0] LAST = '1;

   sweep_state_e  state_q;
   logic [AW-1:0] cnt_q;
   logic [AW-1:0] cnt_d;
   logic          we_q;
   logic          ready_q;

   assign cnt_d = cnt_q + 1'b1;

   // Sweep FSM: counter, write strobe and ready are all registered here
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= CLREN ? ST_CLEAR : ST_RUN;
         cnt_q   <= '0;
         we_q    <= CLREN;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               if (cnt_q == LAST) begin
                  // final address is written on this edge; hand over to RUN
                  state_q <= ST_RUN;
                  we_q    <= 1'b0;
                  ready_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_RUN: begin
               we_q    <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= ST_RUN;
               we_q    <= 1'b0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign addr_o  = cnt_q;
   assign we_o    = we_q;
   assign ready_o = ready_q;

endmodule : ram_sweep

`default_nettype wire

// File: rtl/dpram_clr.sv
// ============================================================================
// Module  : dpram_clr
// Single-clock true dual-port RAM with per-byte write enables, write-first
// same-port reads, cross-port write forwarding, an optional output register
// and a hardware clear sweep of the whole array after every reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dpram_clr
   import dpram_clr_pkg::*;
#(
   parameter int            AW    = 10,
   parameter int            DW    = 8,
   parameter bit            OREG  = 1'b0,
   parameter bit            CLREN = 1'b1,
   parameter logic [DW-1:0] CLRV  = '0
) (
   input  logic                   clock,
   input  logic                   reset,
   output logic                   ready,
   input  logic [AW-1:0]          a1,
   input  logic [DW-1:0]          d1,
   input  logic [DW/BYTE_W-1:0]   w1,
   output logic [DW-1:0]          q1,
   input  logic [AW-1:0]          a2,
   input  logic [DW-1:0]          d2,
   input  logic [DW/BYTE_W-1:0]   w2,
   output logic [DW-1:0]          q2
);

   localparam int NB    = lanes(DW);
   localparam int DEPTH = 2 ** AW;

   // ------------------------------------------------------------------------
   // Clear sequencer
   // ------------------------------------------------------------------------
   logic [AW-1:0] sw_addr;
   logic          sw_we;
   logic          sw_ready;

   ram_sweep #(
      .AW    (AW),
      .CLREN (CLREN)
   ) u_sweep (
      .clk_i   (clock),
      .rst_i   (reset),
      .addr_o  (sw_addr),
      .we_o    (sw_we),
      .ready_o (sw_ready)
   );

   assign ready = sw_ready;

   // ------------------------------------------------------------------------
   // Effective port controls. User writes only land once ready is up; the
   // sweep borrows port 2 with every lane enabled while it runs.
   // ------------------------------------------------------------------------
   logic          run_w;
   logic          clr_w;
   logic [NB-1:0] we1_w;
   logic [NB-1:0] we2_w;
   logic [AW-1:0] a2_w;
   logic [DW-1:0] d2_w;
   logic          same_w;

   assign run_w  = sw_ready & ~reset;
   assign clr_w  = sw_we & ~reset;
   assign we1_w  = run_w ? w1 : '0;
   assign we2_w  = clr_w ? '1 : (run_w ? w2 : '0);
   assign a2_w   = sw_we ? sw_addr : a2;
   assign d2_w   = sw_we ? CLRV : d2;
   assign same_w = (a1 == a2_w);

   // ------------------------------------------------------------------------
   // Byte-lane storage and per-lane read merge
   // ------------------------------------------------------------------------
   logic [DW-1:0] q1_d;
   logic [DW-1:0] q2_d;

   for (genvar i = 0; i < NB; i++) begin : g_lane
      logic [BYTE_W-1:0] mem_q [DEPTH];
      logic [BYTE_W-1:0] rd1_w;
      logic [BYTE_W-1:0] rd2_w;
      logic [BYTE_W-1:0] b1_w;
      logic [BYTE_W-1:0] b2_w;
      logic              st1_w;

      assign rd1_w = mem_q[a1];
      assign rd2_w = mem_q[a2_w];
      assign b1_w  = d1[BYTE_W*i +: BYTE_W];
      assign b2_w  = d2_w[BYTE_W*i +: BYTE_W];
      // on a same-address same-lane collision port 2 owns the byte
      assign st1_w = we1_w[i] & ~(same_w & we2_w[i]);

      // Lane write: port 1 unless overridden by a colliding port-2 write
      always_ff @(posedge clock) begin
         if (st1_w) begin
            mem_q[a1] <= b1_w;
         end
         if (we2_w[i]) begin
            mem_q[a2_w] <= b2_w;
         end
      end

      // Port 1 sees port 2's byte first, then its own, then the array
      assign q1_d[BYTE_W*i +: BYTE_W] = (same_w & we2_w[i]) ? b2_w :
                                        we1_w[i]            ? b1_w : rd1_w;
      // Port 2 sees its own byte first, then port 1's, then the array
      assign q2_d[BYTE_W*i +: BYTE_W] = we2_w[i]            ? b2_w :
                                        (same_w & we1_w[i]) ? b1_w : rd2_w;
   end

   // ------------------------------------------------------------------------
   // Read pipeline. Stage 1 holds the forwarded result; outputs stay zero
   // until the array is usable.
   // ------------------------------------------------------------------------
   logic [DW-1:0] q1_q;
   logic [DW-1:0] q2_q;

   // Stage 1: registered read data with forwarding already resolved
   always_ff @(posedge clock) begin
      if (reset || !sw_ready) begin
         q1_q <= '0;
         q2_q <= '0;
      end else begin
         q1_q <= q1_d;
         q2_q <= q2_d;
      end
   end

   if (OREG) begin : g_oreg
      logic [DW-1:0] q1_p_q;
      logic [DW-1:0] q2_p_q;

      // Stage 2: plain retiming register for timing closure
      always_ff @(posedge clock) begin
         if (reset) begin
            q1_p_q <= '0;
            q2_p_q <= '0;
         end else begin
            q1_p_q <= q1_q;
            q2_p_q <= q2_q;
         end
      end

      assign q1 = q1_p_q;
      assign q2 = q2_p_q;
   end else begin : g_noreg
      assign q1 = q1_q;
      assign q2 = q2_q;
   end

endmodule : dpram_clr

`default_nettype wire

// File: tb/tb_dpram_clr.sv
// ============================================================================
// Module  : tb_dpram_clr
// Directed bench for dpram_clr. Two instances share stimulus: one with a
// single-cycle read path and one with the extra output register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dpram_clr;

   localparam int AW = 4;
   localparam int DW = 16;
   localparam int NB = 2;
   localparam logic [DW-1:0] FILL = 16'hA5A5;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] a1 = '0;
   logic [DW-1:0] d1 = '0;
   logic [NB-1:0] w1 = '0;
   logic [AW-1:0] a2 = '0;
   logic [DW-1:0] d2 = '0;
   logic [NB-1:0] w2 = '0;

   logic          ready0, ready1;
   logic [DW-1:0] q10, q20, q11, q21;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   dpram_clr #(
      .AW(AW), .DW(DW), .OREG(1'b0), .CLREN(1'b1), .CLRV(FILL)
   ) u_dut0 (
      .clock(clock), .reset(reset), .ready(ready0),
      .a1(a1), .d1(d1), .w1(w1), .q1(q10),
      .a2(a2), .d2(d2), .w2(w2), .q2(q20)
   );

   dpram_clr #(
      .AW(AW), .DW(DW), .OREG(1'b1), .CLREN(1'b1), .CLRV(FILL)
   ) u_dut1 (
      .clock(clock), .reset(reset), .ready(ready1),
      .a1(a1), .d1(d1), .w1(w1), .q1(q11),
      .a2(a2), .d2(d2), .w2(w2), .q2(q21)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_ports();
      w1 = '0;
      w2 = '0;
      d1 = '0;
      d2 = '0;
   endtask

   // Counts cycles until ready; flags any non-zero read data seen meanwhile
   task automatic wait_ready(output int n, output bit qbad);
      n    = 0;
      qbad = 1'b0;
      while (ready0 !== 1'b1 && n < 64) begin
         step();
         n++;
         if (ready0 !== 1'b1 && (q10 | q20 | q11 | q21) !== 16'h0000) qbad = 1'b1;
      end
   endtask

   task automatic preload_garbage();
      for (int k = 0; k < 16; k++) begin
         a1 = AW'(k);
         d1 = 16'hDE00 | 16'(k);
         w1 = 2'b11;
         step();
      end
      idle_ports();
   endtask

   task automatic read_all(input string tag);
      for (int k = 0; k < 16; k++) begin
         a1 = AW'(k);
         a2 = AW'(15 - k);
         step();
         check($sformatf("%s_l1_q1_%0d", tag, k), q10, FILL);
         check($sformatf("%s_l1_q2_%0d", tag, 15 - k), q20, FILL);
         step();
         check($sformatf("%s_l2_q1_%0d", tag, k), q11, FILL);
         check($sformatf("%s_l2_q2_%0d", tag, 15 - k), q21, FILL);
      end
   endtask

   initial begin
      int n;
      bit qbad;

      // ---------------- reset state ----------------
      repeat (3) step();
      check("rst_ready0", ready0, 0);
      check("rst_ready1", ready1, 0);
      check("rst_q10", q10, 0);
      check("rst_q20", q20, 0);
      check("rst_q11", q11, 0);
      check("rst_q21", q21, 0);

      reset = 1'b0;
      wait_ready(n, qbad);
      check("sweep0_len", n, 16);
      check("sweep0_ready1", ready1, 1);

      // ---------------- test 1 + 6: garbage, reset pulse, writes ignored during sweep ----------------
      preload_garbage();
      a1 = 4'd5;
      step();
      check("garbage_rd5", q10, 16'hDE05);

      reset = 1'b1;
      step();
      check("pulse_ready", ready0, 0);
      check("pulse_q1", q10, 0);
      reset = 1'b0;
      a1 = 4'd2; a2 = 4'd2;
      d1 = 16'hFFFF; d2 = 16'hFFFF;
      w1 = 2'b11;    w2 = 2'b11;
      wait_ready(n, qbad);
      idle_ports();
      check("sweep1_len", n, 16);
      check("sweep1_qzero", qbad, 0);
      check("sweep1_ready1", ready1, 1);
      read_all("t1");

      // ---------------- test 2: reset at sweep cycle 7 ----------------
      preload_garbage();
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (7) step();
      check("mid_ready", ready0, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      wait_ready(n, qbad);
      check("sweep2_len", n, 16);
      check("sweep2_qzero", qbad, 0);
      read_all("t2");

      // ---------------- test 3: byte enable and write-first ----------------
      a1 = 4'd3; d1 = 16'h1234; w1 = 2'b01;
      a2 = 4'd0;
      step();
      idle_ports();
      check("wf_q1", q10, 16'hA534);
      step();
      check("be_q1", q10, 16'hA534);
      check("be_q1_oreg", q11, 16'hA534);

      // ---------------- test 4: cross-port forwarding ----------------
      a1 = 4'd5; a2 = 4'd5; d2 = 16'h0077; w2 = 2'b01;
      step();
      idle_ports();
      check("fwd21_q1", q10, 16'hA577);
      check("fwd21_q2", q20, 16'hA577);
      step();
      check("fwd21_q1_oreg", q11, 16'hA577);
      check("fwd21_q1_mem", q10, 16'hA577);

      a1 = 4'd6; a2 = 4'd6; d1 = 16'h3300; w1 = 2'b10;
      step();
      idle_ports();
      check("fwd12_q2", q20, 16'h33A5);
      check("fwd12_q1", q10, 16'h33A5);
      step();
      check("fwd12_q2_oreg", q21, 16'h33A5);

      // ---------------- test 5: collisions ----------------
      a1 = 4'd9; a2 = 4'd9;
      d1 = 16'h1111; d2 = 16'h2222; w1 = 2'b11; w2 = 2'b11;
      step();
      idle_ports();
      check("col_q1", q10, 16'h2222);
      check("col_q2", q20, 16'h2222);
      step();
      check("col_q1_oreg", q11, 16'h2222);
      check("col_q2_oreg", q21, 16'h2222);

      a1 = 4'd10; a2 = 4'd10;
      d1 = 16'h1111; d2 = 16'h2222; w1 = 2'b11; w2 = 2'b10;
      step();
      idle_ports();
      check("merge_q1", q10, 16'h2211);
      check("merge_q2", q20, 16'h2211);

      a1 = 4'd9; a2 = 4'd10;
      step();
      check("col_rd9", q10, 16'h2222);
      check("merge_rd10", q20, 16'h2211);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_dpram_clr

`default_nettype wire
